cavlc_block_seq: RTL and testbench

Parametrised successor to the single-block CAVLC control FSM. It sequences CoeffToken, Level and Zero decode across NumBlocks consecutive 4x4 blocks per Enable request. It muxes barrel-shifter control from the active decoder. It also adds a per-phase watchdog and block indexing. It sits between external macroblock control and the CoeffTokenDecode, LevelDecode, ZeroDecode and barrel-shifter blocks.

---
 rtl/cavlc_block_seq.sv | 211 +++++++++++++++++++++
 tb/tb_cavlc_block_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_block_seq.sv
// cavlc_block_seq
//   Sequences CoeffToken -> Level -> Zero decode over NumBlocks consecutive
//   4x4 blocks per Enable request. Muxes barrel-shifter control from the
//   active decoder. A per-phase watchdog aborts a stalled WAIT_BS, LEVEL or
//   ZERO phase.
//
// Optional build macro: CAVLC_SKIP_EMPTY_EN
//   When defined, a block whose TotalCoeff is zero goes from COEFF_1 straight
//   to NEXT, skipping LEVEL and ZERO.
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   Enable                      start request / continue qualifier in NEXT
//   NumBlocks                   blocks per sequence (0 treated as 1)
//   BarrelShifterReady          barrel shifter holds valid data
//   TotalCoeff                  from CoeffTokenDecode, valid in COEFF_1
//   NumShift_*/ShiftEn_*        per-decoder shift requests
//   LevelDecodeDone/ZeroDecodeDone  phase completion
//   ShiftEn, NumShift           combinational shift strobe/amount
//   *DecodeEnable, BarrelShiftEn    registered enables
//   BlockDone, SequenceDone, Timeout one-cycle pulses
//   BlockIndex                  0-based index of current block
//   Busy                        state is not IDLE
module cavlc_block_seq #(
  parameter int SHIFT_W = 5,
  parameter int COEFF_W = 5,
  parameter int NBLK_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [NBLK_W-1:0]  NumBlocks,
  input  logic               BarrelShifterReady,
  input  logic [COEFF_W-1:0] TotalCoeff,
  input  logic [SHIFT_W-1:0] NumShift_CoeffTokenDecode,
  input  logic [SHIFT_W-1:0] NumShift_LevelDecode,
  input  logic               ShiftEn_LevelDecode,
  input  logic [SHIFT_W-1:0] NumShift_ZeroDecode,
  input  logic               ShiftEn_ZeroDecode,
  input  logic               LevelDecodeDone,
  input  logic               ZeroDecodeDone,
  output logic               ShiftEn,
  output logic [SHIFT_W-1:0] NumShift,
  output logic               CoeffTokenDecodeEnable,
  output logic               LevelDecodeEnable,
  output logic               ZeroDecodeEnable,
  output logic               BarrelShiftEn,
  output logic               BlockDone,
  output logic               SequenceDone,
  output logic               Timeout,
  output logic [NBLK_W-1:0]  BlockIndex,
  output logic               Busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_BS = 3'd1,
    COEFF_0 = 3'd2,
    COEFF_1 = 3'd3,
    LEVEL   = 3'd4,
    ZERO    = 3'd5,
    NEXT    = 3'd6
  } state_t;

  // Counter only ever reaches TIMEOUT-1 before the phase is left.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NBLK_W-1:0]  cnt_q, cnt_d;
  logic [NBLK_W-1:0]  blk_q, blk_d;
  logic               ctde_q, lde_q, zde_q, bse_q;
  logic               bdone_q, sdone_q, tout_q;
  logic               wd_expire;
  logic               at_limit;
  logic               last_blk;

`ifndef CAVLC_SKIP_EMPTY_EN
  logic unused_total_coeff;
  assign unused_total_coeff = ^TotalCoeff;
`endif

  assign last_blk = (blk_q == cnt_q - 1'b1);
  assign at_limit = (wd_q == WD_LIMIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    wd_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (Enable) begin
          cnt_d   = (NumBlocks == '0) ? NBLK_W'(1) : NumBlocks;
          blk_d   = '0;
          state_d = WAIT_BS;
        end
      end
      WAIT_BS: begin
        if (BarrelShifterReady) begin
          state_d = COEFF_0;
        end else if (at_limit) begin
          state_d   = IDLE;
          wd_expire = 1'b1;
        end
      end
      COEFF_0: state_d = COEFF_1;
      COEFF_1: begin
`ifdef CAVLC_SKIP_EMPTY_EN
        state_d = (TotalCoeff == '0) ? NEXT : LEVEL;
`else
        state_d = LEVEL;
`endif
      end
      LEVEL: begin
        if (LevelDecodeDone) begin
          state_d = ZERO;
        end else if (at_limit) begin
          state_d   = IDLE;
          wd_expire = 1'b1;
        end
      end
      ZERO: begin
        if (ZeroDecodeDone) begin
          state_d = NEXT;
        end else if (at_limit) begin
          state_d   = IDLE;
          wd_expire = 1'b1;
        end
      end
      NEXT: begin
        if (!last_blk && Enable) begin
          blk_d   = blk_q + 1'b1;
          state_d = COEFF_0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d = '0;
    if (state_d == state_q &&
        (state_q == WAIT_BS || state_q == LEVEL || state_q == ZERO)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_comb begin
    ShiftEn  = 1'b0;
    NumShift = '0;
    case (state_q)
      COEFF_1: begin
        ShiftEn  = 1'b1;
        NumShift = NumShift_CoeffTokenDecode;
      end
      LEVEL: begin
        ShiftEn  = ShiftEn_LevelDecode;
        NumShift = NumShift_LevelDecode;
      end
      ZERO: begin
        ShiftEn  = ShiftEn_ZeroDecode;
        NumShift = NumShift_ZeroDecode;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      ctde_q  <= 1'b0;
      lde_q   <= 1'b0;
      zde_q   <= 1'b0;
      bse_q   <= 1'b0;
      bdone_q <= 1'b0;
      sdone_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      ctde_q  <= (state_q == COEFF_0);
      lde_q   <= (state_q == LEVEL);
      zde_q   <= (state_q == ZERO);
      bse_q   <= !(state_q == IDLE && !Enable);
      bdone_q <= (state_d == NEXT) && (state_q != NEXT);
      sdone_q <= (state_q == NEXT) && last_blk;
      tout_q  <= wd_expire;
    end
  end

  assign CoeffTokenDecodeEnable = ctde_q;
  assign LevelDecodeEnable      = lde_q;
  assign ZeroDecodeEnable       = zde_q;
  assign BarrelShiftEn          = bse_q;
  assign BlockDone              = bdone_q;
  assign SequenceDone           = sdone_q;
  assign Timeout                = tout_q;
  assign BlockIndex             = blk_q;
  assign Busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_cavlc_block_seq.sv
module tb_cavlc_block_seq;
  localparam int SHIFT_W = 5;
  localparam int COEFF_W = 5;
  localparam int NBLK_W  = 5;
  localparam int TIMEOUT = 8;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               Enable;
  logic [NBLK_W-1:0]  NumBlocks;
  logic               BarrelShifterReady;
  logic [COEFF_W-1:0] TotalCoeff;
  logic [SHIFT_W-1:0] NumShift_CoeffTokenDecode;
  logic [SHIFT_W-1:0] NumShift_LevelDecode;
  logic               ShiftEn_LevelDecode;
  logic [SHIFT_W-1:0] NumShift_ZeroDecode;
  logic               ShiftEn_ZeroDecode;
  logic               LevelDecodeDone;
  logic               ZeroDecodeDone;
  logic               ShiftEn;
  logic [SHIFT_W-1:0] NumShift;
  logic               CoeffTokenDecodeEnable;
  logic               LevelDecodeEnable;
  logic               ZeroDecodeEnable;
  logic               BarrelShiftEn;
  logic               BlockDone;
  logic               SequenceDone;
  logic               Timeout;
  logic [NBLK_W-1:0]  BlockIndex;
  logic               Busy;

  // Decoder responders: in auto mode Done follows the registered enable,
  // giving a two-cycle LEVEL/ZERO phase; otherwise driven manually.
  logic lvl_auto, lvl_manual;
  assign LevelDecodeDone = lvl_auto ? LevelDecodeEnable : lvl_manual;
  assign ZeroDecodeDone  = ZeroDecodeEnable;

  int checks = 0;
  int errors = 0;

  int bd_cnt = 0, sd_cnt = 0, to_cnt = 0, lde_cnt = 0, busy_cnt = 0;
  logic [NBLK_W-1:0] idx_log [0:63];

  cavlc_block_seq #(
    .SHIFT_W(SHIFT_W),
    .COEFF_W(COEFF_W),
    .NBLK_W (NBLK_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk                      (Clk),
    .Reset                    (Reset),
    .Enable                   (Enable),
    .NumBlocks                (NumBlocks),
    .BarrelShifterReady       (BarrelShifterReady),
    .TotalCoeff               (TotalCoeff),
    .NumShift_CoeffTokenDecode(NumShift_CoeffTokenDecode),
    .NumShift_LevelDecode     (NumShift_LevelDecode),
    .ShiftEn_LevelDecode      (ShiftEn_LevelDecode),
    .NumShift_ZeroDecode      (NumShift_ZeroDecode),
    .ShiftEn_ZeroDecode       (ShiftEn_ZeroDecode),
    .LevelDecodeDone          (LevelDecodeDone),
    .ZeroDecodeDone           (ZeroDecodeDone),
    .ShiftEn                  (ShiftEn),
    .NumShift                 (NumShift),
    .CoeffTokenDecodeEnable   (CoeffTokenDecodeEnable),
    .LevelDecodeEnable        (LevelDecodeEnable),
    .ZeroDecodeEnable         (ZeroDecodeEnable),
    .BarrelShiftEn            (BarrelShiftEn),
    .BlockDone                (BlockDone),
    .SequenceDone             (SequenceDone),
    .Timeout                  (Timeout),
    .BlockIndex               (BlockIndex),
    .Busy                     (Busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (BlockDone) begin
      idx_log[bd_cnt[5:0]] = BlockIndex;
      bd_cnt++;
    end
    if (SequenceDone)      sd_cnt++;
    if (Timeout)           to_cnt++;
    if (LevelDecodeEnable) lde_cnt++;
    if (Busy)              busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(Busy), 0);
  endtask

  task automatic wait_level(input string tag);
    int n = 0;
    while (NumShift != 5'd7 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(NumShift), 7);
  endtask

  task automatic start(input logic [NBLK_W-1:0] nb, input logic hold);
    NumBlocks = nb;
    Enable    = 1'b1;
    tick();
    if (!hold) Enable = 1'b0;
  endtask

  int bd0, sd0, to0, lde0, busy0;

  initial begin
    Reset = 1'b1; Enable = 1'b0; NumBlocks = '0; BarrelShifterReady = 1'b0;
    TotalCoeff = 5'd3; NumShift_CoeffTokenDecode = 5'd4;
    NumShift_LevelDecode = 5'd7; ShiftEn_LevelDecode = 1'b1;
    NumShift_ZeroDecode = 5'd9; ShiftEn_ZeroDecode = 1'b1;
    lvl_auto = 1'b1; lvl_manual = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Reset state; IDLE mux gives zero even with decoder requests active
    check("rst_busy", 32'(Busy), 0);
    check("rst_shiften", 32'(ShiftEn), 0);
    check("rst_numshift", 32'(NumShift), 0);
    check("rst_bse", 32'(BarrelShiftEn), 0);
    check("rst_outs", {BlockDone, SequenceDone, Timeout, CoeffTokenDecodeEnable,
                       LevelDecodeEnable, ZeroDecodeEnable}, 0);
    check("rst_idx", 32'(BlockIndex), 0);

    // Single block, cycle by cycle
    start(5'd1, 1'b0);                         // -> WAIT_BS
    check("s_busy", 32'(Busy), 1);
    check("s_bse", 32'(BarrelShiftEn), 1);
    tick();                                    // still WAIT_BS
    check("s_wait_shift", 32'(ShiftEn), 0);
    BarrelShifterReady = 1'b1;
    tick();                                    // COEFF_0
    check("s_c0_shift", 32'(ShiftEn), 0);
    tick();                                    // COEFF_1
    check("s_c1_ctde", 32'(CoeffTokenDecodeEnable), 1);
    check("s_c1_shift", {ShiftEn, 3'b0, NumShift}, {1'b1, 3'b0, 5'd4});
    tick();                                    // LEVEL
    check("s_lv_shift", {ShiftEn, 3'b0, NumShift}, {1'b1, 3'b0, 5'd7});
    check("s_lv_lde", 32'(LevelDecodeEnable), 0);
    tick();                                    // LEVEL, enable registered
    check("s_lv_lde2", 32'(LevelDecodeEnable), 1);
    tick();                                    // ZERO
    check("s_zr_shift", 32'(NumShift), 9);
    tick();                                    // ZERO
    check("s_zr_zde", 32'(ZeroDecodeEnable), 1);
    tick();                                    // NEXT
    check("s_nx_bdone", 32'(BlockDone), 1);
    check("s_nx_shift", 32'(ShiftEn), 0);
    check("s_nx_busy", 32'(Busy), 1);
    check("s_nx_idx", 32'(BlockIndex), 0);
    tick();                                    // IDLE
    check("s_id_sdone", 32'(SequenceDone), 1);
    check("s_id_bdone", 32'(BlockDone), 0);
    check("s_id_busy", 32'(Busy), 0);
    check("s_id_shift", {ShiftEn, 3'b0, NumShift}, 0);
    tick();
    check("s_id_sdone2", 32'(SequenceDone), 0);
    check("s_id_bse", 32'(BarrelShiftEn), 0);

    // Multi-block, Enable held high; busy cycles 1 (WAIT_BS) + 4*7
    bd0 = bd_cnt; sd0 = sd_cnt; busy0 = busy_cnt;
    start(5'd4, 1'b1);
    begin
      int n = 0;
      while (!SequenceDone && n < 100) begin tick(); n++; end
    end
    check("m_sdone_seen", 32'(SequenceDone), 1);
    Enable = 1'b0;
    tick(); tick();
    check("m_bdone_cnt", 32'(bd_cnt - bd0), 4);
    check("m_sdone_cnt", 32'(sd_cnt - sd0), 1);
    check("m_busy_cycles", 32'(busy_cnt - busy0), 29);
    for (int i = 0; i < 4; i++)
      check($sformatf("m_idx%0d", i), 32'(idx_log[6'(bd0 + i)]), 32'(i));
    check("m_idle", 32'(Busy), 0);

    // Abort: drop Enable during block 1
    bd0 = bd_cnt; sd0 = sd_cnt;
    start(5'd4, 1'b1);
    begin
      int n = 0;
      while (BlockIndex != 5'd1 && n < 100) begin tick(); n++; end
    end
    Enable = 1'b0;
    wait_idle("a_idle");
    tick();
    check("a_bdone_cnt", 32'(bd_cnt - bd0), 2);
    check("a_sdone_cnt", 32'(sd_cnt - sd0), 0);
    check("a_idx", 32'(BlockIndex), 1);

    // NumBlocks=0 is treated as one block
    bd0 = bd_cnt; sd0 = sd_cnt;
    start(5'd0, 1'b0);
    wait_idle("z_idle");
    tick();
    check("z_bdone_cnt", 32'(bd_cnt - bd0), 1);
    check("z_sdone_cnt", 32'(sd_cnt - sd0), 1);

    // Watchdog: LevelDecodeDone never arrives; pulse 8 edges after LEVEL entry
    lvl_auto = 1'b0; lvl_manual = 1'b0;
    to0 = to_cnt; bd0 = bd_cnt;
    start(5'd1, 1'b0);
    wait_level("w_enter");
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      check($sformatf("w_tout_c%0d", i), 32'(Timeout), 32'(i == TIMEOUT));
    end
    check("w_busy", 32'(Busy), 0);
    tick();
    check("w_tout_cnt", 32'(to_cnt - to0), 1);
    check("w_bdone_cnt", 32'(bd_cnt - bd0), 0);

    // Watchdog: Done on the 8th LEVEL cycle wins
    to0 = to_cnt; bd0 = bd_cnt;
    start(5'd1, 1'b0);
    wait_level("w2_enter");
    repeat (TIMEOUT - 1) tick();
    lvl_manual = 1'b1;
    tick();
    lvl_manual = 1'b0;
    check("w2_zero", 32'(NumShift), 9);
    check("w2_tout", 32'(Timeout), 0);
    lvl_auto = 1'b1;
    wait_idle("w2_idle");
    tick();
    check("w2_tout_cnt", 32'(to_cnt - to0), 0);
    check("w2_bdone_cnt", 32'(bd_cnt - bd0), 1);

    // Reset mid-operation: no Done or Timeout pulse
    bd0 = bd_cnt; sd0 = sd_cnt; to0 = to_cnt;
    start(5'd1, 1'b0);
    wait_level("r_enter");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("r_busy", 32'(Busy), 0);
    check("r_lde", 32'(LevelDecodeEnable), 0);
    tick(); tick();
    check("r_pulses", 32'((bd_cnt - bd0) + (sd_cnt - sd0) + (to_cnt - to0)), 0);

    // Empty block
    TotalCoeff = '0;
    bd0 = bd_cnt; lde0 = lde_cnt;
    start(5'd1, 1'b0);
    wait_idle("e_idle");
    tick();
    check("e_bdone_cnt", 32'(bd_cnt - bd0), 1);
`ifdef CAVLC_SKIP_EMPTY_EN
    check("e_lde_cnt", 32'(lde_cnt - lde0), 0);
`else
    check("e_lde_cnt", 32'(lde_cnt - lde0), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
